mc_ctrl_datapath_core: RTL and testbench
========================================

// Module: mc_ctrl_datapath_core
// PURPOSE
//  Control-plus-ALU core of the multicycle MIPS CPU. Contains three parts:
//  - a Moore FSM that sequences fetch/decode/execute;
//  - an ALU-control decoder (alu_op + func -> 3-bit ALU operation);
//  - a 32-bit combinational ALU.
//  The CPU top owns PC, IR, MDR, ALUOut, the register file and the operand muxes, and drives this block.
// PARAMETERS
//  WIDTH  32  ALU datapath width (only 32 is verified)
// PORTS
//  clk         in   1   rising-edge clock; the only clock
//  reset       in   1   synchronous, active-high reset
//  op          in   6   IR[31:26] opcode
//  func        in   6   IR[5:0] R-type function field
//  alu_a_in    in   32  ALU operand A (PC or rs, selected by the top via alu_srca)
//  alu_b_in    in   32  ALU operand B (rt, 4, sext imm, or sext imm<<2)
//  pc_res      out  1   memory address select: 0 = PC, 1 = ALUOut
//  pc_w        out  1   unconditional PC write
//  pc_wc       out  1   PC write qualified by alu_zero_out (beq)
//  pc_src      out  2   next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  mem_r       out  1   memory read
//  mem_w       out  1   memory write
//  ireg_w      out  1   IR load
//  regdst      out  1   register write address: 1 = rd, 0 = rt
//  reg_w       out  1   register-file write
//  memtoreg    out  1   register write data: 1 = MDR, 0 = ALUOut
//  alu_srca    out  1   ALU A select: 0 = PC, 1 = rs
//  alu_srcb    out  2   ALU B select: 00 = rt, 01 = 4, 10 = sext imm, 11 = sext imm<<2
//  alu_op      out  2   ALU-control class: 00 = add, 01 = sub, 10 = use func
//  state       out  4   current FSM state (debug/display)
//  alu_oper    out  3   decoded ALU operation
//  alu_result_out   out  32  ALU result
//  alu_zero_out     out  1   1 when alu_result_out == 0
//  alu_overflow_out out  1   signed overflow on add/sub
// BEHAVIOUR
//  FSM
//  - The state register is updated on the rising edge of clk; reset synchronously loads 0 (FETCH).
//  - All outputs are decoded from state only; every signal not listed for a state is 0.
//  - While reset=1, pc_w, pc_wc, mem_r, mem_w, ireg_w and reg_w are forced to 0.
//  - Asserting reset in any state returns the FSM to FETCH on the next edge.
//  States, outputs, and next state:
//  0 FETCH: mem_r, ireg_w, pc_w, alu_srcb=01, pc_src=00 -> 1
//  1 DECODE: alu_srcb=11 -> branches on op:
//    lw(100011) or sw(101011) -> 2; R-type(000000) -> 6; beq(000100) -> 8;
//    j(000010) -> 9; addi(001000) -> 10; any other op -> 0
//  2 MEMADR: alu_srca=1, alu_srcb=10 -> 3 for lw, 5 for sw
//  3 MEMRD: mem_r, pc_res -> 4
//  4 MEMWB: reg_w, memtoreg (regdst=0) -> 0
//  5 MEMWR: mem_w, pc_res -> 0
//  6 EXEC: alu_srca=1, alu_srcb=00, alu_op=10 -> 7
//  7 RWB: reg_w, regdst -> 0
//  8 BEQ: alu_srca=1, alu_srcb=00, alu_op=01, pc_wc, pc_src=01 -> 0
//  9 JUMP: pc_w, pc_src=10 -> 0
//  10 ADDIEX: alu_srca=1, alu_srcb=10 -> 11
//  11 ADDIWB: reg_w (regdst=0, memtoreg=0) -> 0
//  12-15: unused; all outputs 0, next state 0.
//  Instruction latency (cycles): lw 5; sw, R-type, addi 4; beq, j 3.
//  ALU control (combinational)
//  - alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD.
//  - alu_op 10 decodes func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR,
//    100111 NOR, 101010 SLT, 000010 SRL; any other func -> ADD.
//  ALU (combinational, 32-bit, wraps modulo 2^32)
//  - Encodings: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL (B>>1, logical),
//    110 SUB (A-B), 111 SLT (signed A<B -> 1, else 0).
//  - SLT is computed as sign(A-B) XOR overflow(A-B).
//  - Overflow is 1 only for ADD or SUB when the signs of the operands and the result
//    indicate signed overflow; 0 for all other operations.
//  - Zero reflects the final result for every operation.
// STRUCTURE
//  - Shared package: state encodings, opcode constants, func constants, 3-bit ALU operation codes.
//  - One sub-module, mc_alu32 (the pure combinational ALU).
//  - FSM and ALU-control decode live in this module.
// TESTING
//  1. Reset is held 2 cycles, then op=100011 (lw) -> state sequence 0,1,2,3,4,0.
//     In state 4: reg_w=1, memtoreg=1. In state 3: pc_res=1.
//  2. op=000000, func=100010, A=5, B=7 -> in state 6: alu_oper=110, result=32'hFFFFFFFE, zero=0, ovf=0.
//     Next state 7, with reg_w=1 and regdst=1.
//  3. ADD with A=32'h7FFFFFFF, B=1 -> result 32'h80000000, overflow=1.
//     SLT with A=-1, B=1 -> result 1.
//  4. op=000100 (beq), A=B=9 -> state 8 with zero=1, pc_wc=1, pc_src=01, then state 0.
//     op=000010 (j) -> state 9 with pc_w=1, pc_src=10.
//  5. Unknown op=111111 -> state goes 1 -> 0 with no write enables.
//     Reset asserted while in state 3 -> state 0 on the next edge; mem_r=0 while reset=1.
//  6. alu_op=10 with func=000000 -> alu_oper=010.
//     SRL with B=32'h80000000 -> result 32'h40000000.

Source files
------------

// File: rtl/mc_ctrl_datapath_core_pkg.sv
// Shared definitions for the multicycle MIPS control core: FSM states, opcodes,
// function codes, ALU operation codes, ALU-control classes and the control word.
package mc_ctrl_datapath_core_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_oper_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       pc_res;
    logic       pc_w;
    logic       pc_wc;
    logic [1:0] pc_src;
    logic       mem_r;
    logic       mem_w;
    logic       ireg_w;
    logic       regdst;
    logic       reg_w;
    logic       memtoreg;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_datapath_core_alu32.sv
// mc_alu32: combinational 32-bit ALU (AND/OR/ADD/XOR/NOR/SRL/SUB/SLT), zero latency.
// Backpressure: none; result, zero and overflow follow the operands in the same cycle.
module mc_alu32
  import mc_ctrl_datapath_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_oper_t        oper,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed overflow: operand signs vs result sign.
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (oper)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = ovf_add;
      end
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SRL: result = b >> 1;
      ALU_SUB: begin
        result   = diff;
        overflow = ovf_sub;
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_ctrl_datapath_core.sv
// Multicycle MIPS control core: Moore FSM, ALU-control decode and 32-bit ALU; outputs decode from state.
// Backpressure: none; one state per clock, enables forced low while reset is high.
module mc_ctrl_datapath_core
  import mc_ctrl_datapath_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] alu_a_in,
  input  logic [WIDTH-1:0] alu_b_in,
  output logic             pc_res,
  output logic             pc_w,
  output logic             pc_wc,
  output logic [1:0]       pc_src,
  output logic             mem_r,
  output logic             mem_w,
  output logic             ireg_w,
  output logic             regdst,
  output logic             reg_w,
  output logic             memtoreg,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [2:0]       alu_oper,
  output logic [WIDTH-1:0] alu_result_out,
  output logic             alu_zero_out,
  output logic             alu_overflow_out
);

  state_t    state_q;
  state_t    state_d;
  ctrl_t     ctrl;
  alu_oper_t oper_dec;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_r    = 1'b1;
        ctrl.ireg_w   = 1'b1;
        ctrl.pc_w     = 1'b1;
        ctrl.alu_srcb = 2'b01;
      end
      S_DECODE: ctrl.alu_srcb = 2'b11;
      S_MEMADR: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_r  = 1'b1;
        ctrl.pc_res = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_w    = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_w  = 1'b1;
        ctrl.pc_res = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_op   = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl.reg_w  = 1'b1;
        ctrl.regdst = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_op   = ALUOP_SUB;
        ctrl.pc_wc    = 1'b1;
        ctrl.pc_src   = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_w   = 1'b1;
        ctrl.pc_src = 2'b10;
      end
      S_ADDIEX: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = 2'b10;
      end
      S_ADDIWB: ctrl.reg_w = 1'b1;
      default: ctrl = '0;
    endcase
    // Keep architectural state untouched during reset regardless of current state.
    if (reset) begin
      ctrl.pc_w   = 1'b0;
      ctrl.pc_wc  = 1'b0;
      ctrl.mem_r  = 1'b0;
      ctrl.mem_w  = 1'b0;
      ctrl.ireg_w = 1'b0;
      ctrl.reg_w  = 1'b0;
    end
  end

  always_comb begin
    oper_dec = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_SUB:  oper_dec = ALU_SUB;
      ALUOP_FUNC: begin
        case (func)
          FUNC_ADD: oper_dec = ALU_ADD;
          FUNC_SUB: oper_dec = ALU_SUB;
          FUNC_AND: oper_dec = ALU_AND;
          FUNC_OR:  oper_dec = ALU_OR;
          FUNC_XOR: oper_dec = ALU_XOR;
          FUNC_NOR: oper_dec = ALU_NOR;
          FUNC_SLT: oper_dec = ALU_SLT;
          FUNC_SRL: oper_dec = ALU_SRL;
          default:  oper_dec = ALU_ADD;
        endcase
      end
      default: oper_dec = ALU_ADD;
    endcase
  end

  mc_alu32 #(.WIDTH(WIDTH)) u_alu (
    .a        (alu_a_in),
    .b        (alu_b_in),
    .oper     (oper_dec),
    .result   (alu_result_out),
    .zero     (alu_zero_out),
    .overflow (alu_overflow_out)
  );

  assign pc_res   = ctrl.pc_res;
  assign pc_w     = ctrl.pc_w;
  assign pc_wc    = ctrl.pc_wc;
  assign pc_src   = ctrl.pc_src;
  assign mem_r    = ctrl.mem_r;
  assign mem_w    = ctrl.mem_w;
  assign ireg_w   = ctrl.ireg_w;
  assign regdst   = ctrl.regdst;
  assign reg_w    = ctrl.reg_w;
  assign memtoreg = ctrl.memtoreg;
  assign alu_srca = ctrl.alu_srca;
  assign alu_srcb = ctrl.alu_srcb;
  assign alu_op   = ctrl.alu_op;
  assign state    = state_q;
  assign alu_oper = oper_dec;

endmodule

// File: tb/tb_mc_ctrl_datapath_core.sv
// Bench for mc_ctrl_datapath_core: per-cycle scoreboard against a behavioural
// state/control/ALU model, an instruction vector table, and explicit corner sequences.
module tb_mc_ctrl_datapath_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, func;
  logic [31:0] a, b;
  logic        pc_res, pc_w, pc_wc, mem_r, mem_w, ireg_w, regdst, reg_w, memtoreg, alu_srca;
  logic [1:0]  pc_src, alu_srcb, alu_op;
  logic [3:0]  state;
  logic [2:0]  alu_oper;
  logic [31:0] alu_result_out;
  logic        alu_zero_out, alu_overflow_out;

  always #5 clk = ~clk;

  mc_ctrl_datapath_core #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .alu_a_in(a), .alu_b_in(b),
    .pc_res(pc_res), .pc_w(pc_w), .pc_wc(pc_wc), .pc_src(pc_src),
    .mem_r(mem_r), .mem_w(mem_w), .ireg_w(ireg_w), .regdst(regdst),
    .reg_w(reg_w), .memtoreg(memtoreg), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .alu_op(alu_op), .state(state), .alu_oper(alu_oper),
    .alu_result_out(alu_result_out), .alu_zero_out(alu_zero_out),
    .alu_overflow_out(alu_overflow_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] model_state;
  logic       cur_rst;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [2:0]  oper;
    logic [31:0] res;
    logic        z;
    logic        v;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Control word order: pc_res pc_w pc_wc pc_src mem_r mem_w ireg_w regdst reg_w memtoreg alu_srca alu_srcb alu_op
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic rst);
    logic pres, pw, pwc, mr, mw, irw, rd, rw, m2r, sa;
    logic [1:0] ps, sb, aop;
    {pres, pw, pwc, mr, mw, irw, rd, rw, m2r, sa} = '0;
    ps = 2'b00; sb = 2'b00; aop = 2'b00;
    case (s)
      4'd0:  begin mr = 1; irw = 1; pw = 1; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; pres = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; pres = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (rst) {pw, pwc, mr, mw, irw, rw} = '0;
    return {pres, pw, pwc, ps, mr, mw, irw, rd, rw, m2r, sa, sb, aop};
  endfunction

  function automatic logic [3:0] next_state(input logic [3:0] s, input logic [5:0] o);
    case (s)
      4'd0: return 4'd1;
      4'd1: begin
        if (o == 6'b100011 || o == 6'b101011) return 4'd2;
        if (o == 6'b000000) return 4'd6;
        if (o == 6'b000100) return 4'd8;
        if (o == 6'b000010) return 4'd9;
        if (o == 6'b001000) return 4'd10;
        return 4'd0;
      end
      4'd2:  return (o == 6'b101011) ? 4'd5 : 4'd3;
      4'd3:  return 4'd4;
      4'd6:  return 4'd7;
      4'd10: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_oper(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic exp_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic v);
    longint full;
    v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b011: r = x ^ y;
      3'b100: r = ~(x | y);
      3'b101: r = {1'b0, y[31:1]};
      3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b010: begin
        r = x + y;
        full = longint'($signed(x)) + longint'($signed(y));
        v = (full != longint'($signed(r)));
      end
      default: begin
        r = x - y;
        full = longint'($signed(x)) - longint'($signed(y));
        v = (full != longint'($signed(r)));
      end
    endcase
  endtask

  // Drive one cycle's inputs, queue the model's expectation, compare at the falling edge.
  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic rst);
    exp_t e, g;
    op = o; func = f; a = x; b = y; reset = rst; cur_rst = rst;
    e.st   = model_state;
    e.ctrl = exp_ctrl(model_state, rst);
    e.oper = exp_oper(e.ctrl[1:0], f);
    exp_alu(e.oper, x, y, e.res, e.v);
    e.z = (e.res == 32'd0);
    sbq.push_back(e);
    @(negedge clk);
    g = sbq.pop_front();
    chk("state", 64'(state), 64'(g.st));
    chk("ctrl", 64'({pc_res, pc_w, pc_wc, pc_src, mem_r, mem_w, ireg_w, regdst, reg_w,
                     memtoreg, alu_srca, alu_srcb, alu_op}), 64'(g.ctrl));
    chk("alu_oper", 64'(alu_oper), 64'(g.oper));
    chk("alu", {30'd0, alu_zero_out, alu_overflow_out, alu_result_out}, {30'd0, g.z, g.v, g.res});
  endtask

  task automatic adv();
    @(posedge clk);
    model_state = cur_rst ? 4'd0 : next_state(model_state, op);
    #1;
  endtask

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    drive(o, f, x, y, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0;
    do begin
      step(v.op, v.func, v.a, v.b);
      adv();
      cyc++;
    end while (model_state != 4'd0 && cyc < 20);
    chk({"lat_", v.name}, 64'(cyc), 64'(v.lat));
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"lw",    6'b100011, 6'd0,      32'd100,        32'd8,          5};
    vecs[1]  = '{"sw",    6'b101011, 6'd0,      32'd200,        32'hFFFFFFFC,   4};
    vecs[2]  = '{"add",   6'b000000, 6'b100000, 32'd3,          32'd4,          4};
    vecs[3]  = '{"and",   6'b000000, 6'b100100, 32'hF0F0FF00,   32'h0FF0F0F0,   4};
    vecs[4]  = '{"or",    6'b000000, 6'b100101, 32'hF0000000,   32'h0000000F,   4};
    vecs[5]  = '{"xor",   6'b000000, 6'b100110, 32'hAAAA5555,   32'hFFFF0000,   4};
    vecs[6]  = '{"nor",   6'b000000, 6'b100111, 32'h0000FFFF,   32'h00FF0000,   4};
    vecs[7]  = '{"slt0",  6'b000000, 6'b101010, 32'd1,          32'hFFFFFFFF,   4};
    vecs[8]  = '{"subov", 6'b000000, 6'b100010, 32'h80000000,   32'd1,          4};
    vecs[9]  = '{"beqne", 6'b000100, 6'd0,      32'd1,          32'd2,          3};
    vecs[10] = '{"addi",  6'b001000, 6'd0,      32'd10,         32'hFFFFFFFD,   4};
    vecs[11] = '{"jump",  6'b000010, 6'd0,      32'd0,          32'd0,          3};

    // Reset for two cycles; the first compare happens once the state is defined.
    op = 6'd0; func = 6'd0; a = 32'd0; b = 32'd0; reset = 1'b1; cur_rst = 1'b1;
    @(posedge clk); #1;
    model_state = 4'd0;
    drive(6'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    adv();
    chk("reset_state", 64'(state), 64'd0);

    // lw: 0,1,2,3,4,0 with pc_res in 3 and reg_w/memtoreg in 4
    for (int s = 0; s < 5; s++) begin
      step(6'b100011, 6'd0, 32'd16, 32'd4);
      chk("lw_seq", 64'(state), 64'(s));
      if (s == 3) chk("lw_pc_res", 64'(pc_res), 64'd1);
      if (s == 4) chk("lw_wb", 64'({reg_w, memtoreg}), 64'b11);
      adv();
    end
    chk("lw_end", 64'(state), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // R-type SUB 5-7
    step(6'b000000, 6'b100010, 32'd5, 32'd7); adv();
    step(6'b000000, 6'b100010, 32'd5, 32'd7);
    adv();
    step(6'b000000, 6'b100010, 32'd5, 32'd7);
    chk("sub_state", 64'(state), 64'd6);
    chk("sub_oper", 64'(alu_oper), 64'b110);
    chk("sub_res", 64'(alu_result_out), 64'hFFFFFFFE);
    chk("sub_zv", 64'({alu_zero_out, alu_overflow_out}), 64'b00);
    adv();
    step(6'b000000, 6'b100010, 32'd5, 32'd7);
    chk("rwb", 64'({state, reg_w, regdst}), {58'd0, 4'd7, 2'b11});
    adv();

    // ADD overflow in FETCH, then an unknown op returns 1 -> 0 with no enables
    step(6'b111111, 6'd0, 32'h7FFFFFFF, 32'd1);
    chk("add_ovf_res", 64'(alu_result_out), 64'h80000000);
    chk("add_ovf", 64'(alu_overflow_out), 64'd1);
    adv();
    step(6'b111111, 6'd0, 32'd0, 32'd0);
    chk("unk_en", 64'({pc_w, pc_wc, mem_r, mem_w, ireg_w, reg_w}), 64'd0);
    adv();
    chk("unk_ret", 64'(state), 64'd0);

    // SLT -1 < 1
    step(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1); adv();
    step(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1); adv();
    step(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1);
    chk("slt_res", 64'(alu_result_out), 64'd1);
    adv();
    step(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1); adv();

    // beq taken
    step(6'b000100, 6'd0, 32'd9, 32'd9); adv();
    step(6'b000100, 6'd0, 32'd9, 32'd9); adv();
    step(6'b000100, 6'd0, 32'd9, 32'd9);
    chk("beq_state", 64'(state), 64'd8);
    chk("beq_ctl", 64'({alu_zero_out, pc_wc, pc_src}), 64'b1101);
    adv();
    chk("beq_ret", 64'(state), 64'd0);

    // j
    step(6'b000010, 6'd0, 32'd0, 32'd0); adv();
    step(6'b000010, 6'd0, 32'd0, 32'd0); adv();
    step(6'b000010, 6'd0, 32'd0, 32'd0);
    chk("j_ctl", 64'({state, pc_w, pc_src}), {57'd0, 4'd9, 3'b110});
    adv();

    // Reset asserted in MEMRD
    for (int s = 0; s < 3; s++) begin
      step(6'b100011, 6'd0, 32'd0, 32'd0);
      adv();
    end
    drive(6'b100011, 6'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_in3_state", 64'(state), 64'd3);
    chk("rst_in3_mem_r", 64'(mem_r), 64'd0);
    adv();
    chk("rst_ret", 64'(state), 64'd0);

    // func 000000 decodes to ADD; SRL of 0x80000000
    step(6'b000000, 6'b000000, 32'd1, 32'd2); adv();
    step(6'b000000, 6'b000000, 32'd1, 32'd2); adv();
    step(6'b000000, 6'b000000, 32'd1, 32'd2);
    chk("func0_oper", 64'(alu_oper), 64'b010);
    adv();
    step(6'b000000, 6'b000000, 32'd1, 32'd2); adv();
    step(6'b000000, 6'b000010, 32'd0, 32'h80000000); adv();
    step(6'b000000, 6'b000010, 32'd0, 32'h80000000); adv();
    step(6'b000000, 6'b000010, 32'd0, 32'h80000000);
    chk("srl_res", 64'(alu_result_out), 64'h40000000);
    adv();
    step(6'b000000, 6'b000010, 32'd0, 32'h80000000); adv();

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
